// File: rtl/reg_seq_pkg.sv
// Shared opcodes, state encoding and default sizes for the register-op sequencer.
package reg_seq_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_OPW   = 2;

    localparam logic [1:0] OP_CLEAR    = 2'b00;
    localparam logic [1:0] OP_LOAD     = 2'b01;
    localparam logic [1:0] OP_ADD_N    = 2'b10;
    localparam logic [1:0] OP_POPCOUNT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LD    = 3'd2,
        S_INC   = 3'd3,
        S_SHIFT = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_e;

endpackage

// File: rtl/reg_seq_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement.
module reg_seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/reg_op_sequencer.sv
// Command-level sequencer driving clr/ld/inc/shr strobes of one datapath register.
// Handshake: start is taken only in IDLE (busy=0); done pulses once, result holds until the next done.
module reg_op_sequencer
    import reg_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] arg,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             reg_clr,
    output logic             reg_ld,
    output logic             reg_inc,
    output logic             reg_shr,
    output logic [WIDTH-1:0] reg_data,
    input  logic [WIDTH-1:0] reg_q,
    input  logic             reg_rc,
    output state_e           dbg_state
);

    state_e           state_q, state_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [WIDTH-1:0] ones_q, ones_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] reg_data_q, reg_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             clr_q, clr_d;
    logic             ld_q, ld_d;
    logic             inc_q, inc_d;
    logic             shr_q, shr_d;

    logic             cnt_load;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_dec;
    logic             cnt_zero;

    reg_seq_counter #(
        .W(WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Outputs are registered, so each strobe is raised on the edge that enters its state.
    // Result is loaded on the edge entering DONE with the value reg_q will hold in DONE.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        arg_d      = arg_q;
        ones_d     = ones_q;
        result_d   = result_q;
        reg_data_d = '0;
        clr_d      = 1'b0;
        ld_d       = 1'b0;
        inc_d      = 1'b0;
        shr_d      = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    arg_d  = arg;
                    ones_d = '0;
                    if (op == OPW'(OP_CLEAR)) begin
                        state_d = S_CLR;
                        clr_d   = 1'b1;
                    end else if (op == OPW'(OP_ADD_N)) begin
                        if (arg == '0) begin
                            state_d  = S_DONE;
                            result_d = reg_q;
                        end else begin
                            state_d  = S_INC;
                            inc_d    = 1'b1;
                            cnt_load = 1'b1;
                            cnt_val  = arg - WIDTH'(1);
                        end
                    end else begin
                        state_d    = S_LD;
                        ld_d       = 1'b1;
                        reg_data_d = arg;
                    end
                end
            end
            S_CLR: begin
                state_d  = S_DONE;
                result_d = '0;
            end
            S_LD: begin
                if (op_q == OPW'(OP_POPCOUNT)) begin
                    state_d  = S_SHIFT;
                    shr_d    = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = WIDTH'(WIDTH - 1);
                end else begin
                    state_d  = S_DONE;
                    result_d = arg_q;
                end
            end
            S_INC: begin
                if (cnt_zero) begin
                    state_d  = S_DONE;
                    result_d = reg_q + WIDTH'(1);
                end else begin
                    inc_d   = 1'b1;
                    cnt_dec = 1'b1;
                end
            end
            S_SHIFT: begin
                ones_d = ones_q + WIDTH'(reg_rc);
                if (cnt_zero) begin
                    state_d = S_DRAIN;
                end else begin
                    shr_d   = 1'b1;
                    cnt_dec = 1'b1;
                end
            end
            S_DRAIN: begin
                // The last shifted-out bit only appears on right_carry after the final shift.
                ones_d   = ones_q + WIDTH'(reg_rc);
                result_d = ones_q + WIDTH'(reg_rc);
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            arg_q      <= '0;
            ones_q     <= '0;
            result_q   <= '0;
            reg_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_q      <= 1'b0;
            ld_q       <= 1'b0;
            inc_q      <= 1'b0;
            shr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            arg_q      <= arg_d;
            ones_q     <= ones_d;
            result_q   <= result_d;
            reg_data_q <= reg_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clr_q      <= clr_d;
            ld_q       <= ld_d;
            inc_q      <= inc_d;
            shr_q      <= shr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign reg_data  = reg_data_q;
    assign reg_clr   = clr_q;
    assign reg_ld    = ld_q;
    assign reg_inc   = inc_q;
    assign reg_shr   = shr_q;
    assign dbg_state = state_q;

endmodule
